// File: rtl/bidimen_demux_pack.sv
// Registered demultiplexer/packer: steers handshaked words into a DEPTH-slot bank
// and hands off the packed bank as a frame once every slot has been written.
module bidimen_demux_pack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 19,
  localparam int SEL_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   d_flush,
  input  logic                   d_auto,
  input  logic [WIDTH-1:0]       d_in,
  input  logic [SEL_WIDTH-1:0]   d_ctrl,
  input  logic                   d_valid,
  output logic                   d_ready,
  output logic                   d_err,
  output logic [DEPTH-1:0]       d_mask,
  output logic [WIDTH*DEPTH-1:0] d_out,
  output logic                   d_out_valid,
  input  logic                   d_out_ready
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0]   bank_q, bank_d;
  logic [DEPTH-1:0]              mask_q, mask_d;
  logic [SEL_WIDTH-1:0]          ptr_q, ptr_d;
  logic                          err_q, err_d;
  logic [SEL_WIDTH-1:0]          addr;
  logic                          addr_ok;
  logic                          accept;

  // Ready is a state decode, additionally held low for the whole time rst is asserted.
  assign d_ready     = (state_q == FILL) && !rst;
  assign d_out_valid = (state_q == HOLD);
  assign d_err       = err_q;
  assign d_mask      = mask_q;
  assign d_out       = bank_q;

  assign addr    = d_auto ? ptr_q : d_ctrl;
  assign addr_ok = (32'(addr) < 32'(DEPTH));
  assign accept  = d_valid && d_ready;

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    err_d   = 1'b0;

    if (d_flush) begin
      mask_d  = '0;
      ptr_d   = '0;
      state_d = FILL;
    end else if (state_q == FILL) begin
      if (accept) begin
        if (addr_ok) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            if (addr == SEL_WIDTH'(i)) begin
              bank_d[i] = d_in;
              mask_d[i] = 1'b1;
            end
          end
        end else begin
          err_d = 1'b1;
        end
        if (d_auto) begin
          ptr_d = (ptr_q == SEL_WIDTH'(DEPTH - 1)) ? '0 : ptr_q + SEL_WIDTH'(1);
        end
        if (&mask_d) begin
          state_d = HOLD;
        end
      end
    end else begin
      if (d_out_ready) begin
        mask_d  = '0;
        ptr_d   = '0;
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      bank_q  <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bidimen_demux_pack.sv
// Bench for bidimen_demux_pack: directed table, hand-written frame sequences and
// random traffic, all checked against an array-based reference model.
module tb_bidimen_demux_pack;
  localparam int W  = 32;
  localparam int D  = 19;
  localparam int SW = 5;

  logic           clk = 1'b0;
  logic           rst, d_flush, d_auto, d_valid, d_out_ready;
  logic [W-1:0]   d_in;
  logic [SW-1:0]  d_ctrl;
  logic           d_ready, d_err, d_out_valid;
  logic [D-1:0]   d_mask;
  logic [W*D-1:0] d_out;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [W-1:0] m_bank [D];
  logic [D-1:0] m_mask;
  int           m_ptr;
  logic         m_hold;
  logic         m_err;

  typedef struct {
    logic         valid;
    logic [SW-1:0] ctrl;
    logic [W-1:0] din;
    logic         exp_err;
    logic [D-1:0] exp_mask;
  } vec_t;
  vec_t tbl [8];

  bidimen_demux_pack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .d_flush(d_flush), .d_auto(d_auto), .d_in(d_in),
    .d_ctrl(d_ctrl), .d_valid(d_valid), .d_ready(d_ready), .d_err(d_err),
    .d_mask(d_mask), .d_out(d_out), .d_out_valid(d_out_valid), .d_out_ready(d_out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W*D-1:0] act, input logic [W*D-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    int a;
    if (rst) begin
      m_hold = 1'b0; m_mask = '0; m_ptr = 0; m_err = 1'b0;
      for (int i = 0; i < D; i++) m_bank[i] = '0;
    end else if (d_flush) begin
      m_hold = 1'b0; m_mask = '0; m_ptr = 0; m_err = 1'b0;
    end else if (m_hold) begin
      m_err = 1'b0;
      if (d_out_ready) begin
        m_hold = 1'b0; m_mask = '0; m_ptr = 0;
      end
    end else begin
      m_err = 1'b0;
      if (d_valid) begin
        a = d_auto ? m_ptr : int'(d_ctrl);
        if (a < D) begin
          m_bank[a] = d_in;
          m_mask[a] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        if (d_auto) m_ptr = (m_ptr + 1) % D;
        if ($countones(m_mask) == D) m_hold = 1'b1;
      end
    end
  endtask

  task automatic compare_model();
    logic [W*D-1:0] exp_out;
    for (int i = 0; i < D; i++) exp_out[i*W +: W] = m_bank[i];
    chk("m_ready", d_ready, (!m_hold && !rst));
    chk("m_out_valid", d_out_valid, m_hold);
    chk("m_err", d_err, m_err);
    chk("m_mask", d_mask, m_mask);
    chk("m_out", d_out, exp_out);
  endtask

  // inputs are stable across the edge; outputs sampled 1 time unit after it
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle();
    d_valid = 1'b0; d_flush = 1'b0; d_out_ready = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    chk("rst_ready_low", d_ready, 1'b0);
    chk("rst_mask", d_mask, '0);
    chk("rst_out", d_out, '0);
    chk("rst_out_valid", d_out_valid, 1'b0);
    chk("rst_err", d_err, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", d_ready, 1'b1);
  endtask

  task automatic word(input logic au, input logic [SW-1:0] c, input logic [W-1:0] v);
    d_auto = au; d_ctrl = c; d_in = v; d_valid = 1'b1;
    cycle();
    d_valid = 1'b0;
  endtask

  initial begin
    logic [W*D-1:0] snap;
    m_mask = '0; m_ptr = 0; m_hold = 1'b0; m_err = 1'b0;
    for (int i = 0; i < D; i++) m_bank[i] = '0;
    d_in = '0; d_ctrl = '0; d_auto = 1'b0;
    idle();
    rst = 1'b1;
    cycle();
    do_reset();

    // auto fill
    for (int i = 0; i < D; i++) begin
      word(1'b1, '0, 32'h1000 + 32'(i));
      if (i == D - 2) chk("fill_not_yet_valid", d_out_valid, 1'b0);
    end
    chk("fill_valid", d_out_valid, 1'b1);
    chk("fill_ready", d_ready, 1'b0);
    chk("fill_mask", d_mask, 19'h7FFFF);
    for (int i = 0; i < D; i++) snap[i*W +: W] = 32'h1000 + 32'(i);
    chk("fill_data", d_out, snap);

    // backpressure
    for (int i = 0; i < 10; i++) begin
      d_valid = 1'(i & 1); d_in = $urandom; d_auto = 1'(i >> 1);
      d_ctrl = SW'(i);
      cycle();
    end
    d_valid = 1'b0;
    chk("bp_mask", d_mask, 19'h7FFFF);
    chk("bp_data", d_out, snap);
    chk("bp_valid", d_out_valid, 1'b1);
    d_out_ready = 1'b1;
    cycle();
    d_out_ready = 1'b0;
    chk("bp_rel_mask", d_mask, '0);
    chk("bp_rel_ready", d_ready, 1'b1);
    chk("bp_rel_valid", d_out_valid, 1'b0);
    chk("bp_data_kept", d_out, snap);

    // manual out-of-order fill with an overwrite of slot 5
    for (int idx = D - 1; idx >= 1; idx--) begin
      word(1'b0, SW'(idx), 32'hA0 + 32'(idx));
      chk("man_no_valid", d_out_valid, 1'b0);
    end
    word(1'b0, 5'd5, 32'hDEAD);
    chk("man_no_valid_rw", d_out_valid, 1'b0);
    word(1'b0, 5'd0, 32'hA0);
    chk("man_valid", d_out_valid, 1'b1);
    chk("man_slot5", d_out[5*W +: W], 32'hDEAD);
    chk("man_slot18", d_out[18*W +: W], 32'hB2);
    chk("man_slot0", d_out[0 +: W], 32'hA0);
    d_out_ready = 1'b1;
    cycle();
    d_out_ready = 1'b0;

    // table: illegal indices interleaved with legal manual writes
    do_reset();
    tbl[0] = '{1'b1, 5'd3,  32'h33,   1'b0, 19'h00008};
    tbl[1] = '{1'b1, 5'd19, 32'hE1,   1'b1, 19'h00008};
    tbl[2] = '{1'b0, 5'd19, 32'hE2,   1'b0, 19'h00008};
    tbl[3] = '{1'b1, 5'd25, 32'hE3,   1'b1, 19'h00008};
    tbl[4] = '{1'b1, 5'd31, 32'hE4,   1'b1, 19'h00008};
    tbl[5] = '{1'b1, 5'd0,  32'h10,   1'b0, 19'h00009};
    tbl[6] = '{1'b1, 5'd18, 32'h1818, 1'b0, 19'h40009};
    tbl[7] = '{1'b1, 5'd3,  32'h3333, 1'b0, 19'h40009};
    d_auto = 1'b0;
    foreach (tbl[k]) begin
      d_valid = tbl[k].valid; d_ctrl = tbl[k].ctrl; d_in = tbl[k].din;
      cycle();
      chk($sformatf("tbl%0d_err", k), d_err, tbl[k].exp_err);
      chk($sformatf("tbl%0d_mask", k), d_mask, tbl[k].exp_mask);
      chk($sformatf("tbl%0d_ready", k), d_ready, 1'b1);
    end
    d_valid = 1'b0;
    cycle();
    chk("tbl_err_clear", d_err, 1'b0);
    chk("tbl_slot3", d_out[3*W +: W], 32'h3333);
    chk("tbl_slot19_none", d_out[4*W +: W], 32'h0);

    // flush
    d_flush = 1'b1;
    cycle();
    d_flush = 1'b0;
    for (int i = 0; i < 7; i++) word(1'b1, '0, 32'h700 + 32'(i));
    chk("fl_mask7", d_mask, 19'h0007F);
    d_flush = 1'b1; d_valid = 1'b1; d_auto = 1'b1; d_in = 32'hBAD;
    cycle();
    d_flush = 1'b0; d_valid = 1'b0;
    chk("fl_mask", d_mask, '0);
    chk("fl_dropped", d_out[7*W +: W], 32'h0);
    chk("fl_kept", d_out[1*W +: W], 32'h701);
    word(1'b1, '0, 32'h55);
    chk("fl_slot0", d_out[0 +: W], 32'h55);
    chk("fl_mask1", d_mask, 19'h00001);

    // reset while holding a frame
    for (int i = 1; i < D; i++) word(1'b1, '0, $urandom);
    chk("rh_valid", d_out_valid, 1'b1);
    do_reset();
    d_valid = 1'b0;
    cycle();
    chk("rh_ready_after", d_ready, 1'b1);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      d_flush     = ($urandom_range(0, 31) == 0);
      d_valid     = ($urandom_range(0, 3) != 0);
      d_auto      = 1'($urandom);
      d_ctrl      = SW'($urandom);
      d_in        = $urandom;
      d_out_ready = ($urandom_range(0, 3) == 0);
      cycle();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
